// File: rtl/audio_pkg.sv
// Shared constants and types for the stereo test-tone source.
package audio_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 1042;

    localparam logic [1:0] WAVE_SQUARE   = 2'b00;
    localparam logic [1:0] WAVE_SAW      = 2'b01;
    localparam logic [1:0] WAVE_TRIANGLE = 2'b10;
    localparam logic [1:0] WAVE_SILENCE  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPhase,
        StShape,
        StScale,
        StSend
    } state_e;

endpackage

// File: rtl/audio_dds_core.sv
// Phase accumulator and waveshaper: advances phase when phase_en_i is set and
// registers the shaped waveform sample when shape_en_i is set.
module audio_dds_core #(
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned DATA_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               phase_en_i,
    input  logic               shape_en_i,
    input  logic [PHASE_W-1:0] tune_word_i,
    input  logic [1:0]         wave_sel_i,
    output logic [DATA_W-1:0]  wave_o
);
    import audio_pkg::*;

    logic [PHASE_W-1:0] phase_q;
    logic [DATA_W-1:0]  wave_q, wave_d;
    logic [DATA_W-1:0]  p, tri_t;

    always_comb begin
        p      = phase_q[PHASE_W-1 -: DATA_W];
        tri_t  = {p[DATA_W-2:0], 1'b0} ^ {1'b1, {(DATA_W-1){1'b0}}};
        wave_d = '0;
        case (wave_sel_i)
            WAVE_SQUARE:   wave_d = p[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                : {1'b0, {(DATA_W-1){1'b1}}};
            WAVE_SAW:      wave_d = p ^ {1'b1, {(DATA_W-1){1'b0}}};
            // Fold the upper half so the ramp runs down again.
            WAVE_TRIANGLE: wave_d = p[DATA_W-1] ? ~tri_t : tri_t;
            default:       wave_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
            wave_q  <= '0;
        end else begin
            if (phase_en_i) phase_q <= phase_q + tune_word_i;
            if (shape_en_i) wave_q  <= wave_d;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: rtl/audio_tone_source.sv
// Stereo DDS test-tone source feeding two Avalon-ST channel sinks with independent
// handshakes; counts sample ticks dropped while a sample is still in flight.
module audio_tone_source #(
    parameter int unsigned CLK_DIV = audio_pkg::CLK_DIV_DEFAULT,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned DATA_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         wave_sel,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic [3:0]         volume,
    output logic [DATA_W-1:0]  left_data,
    output logic               left_valid,
    input  logic               left_ready,
    output logic [DATA_W-1:0]  right_data,
    output logic               right_valid,
    input  logic               right_ready,
    output logic [7:0]         overrun_cnt
);
    import audio_pkg::*;

    localparam int unsigned        DivW    = $clog2(CLK_DIV);
    localparam logic [DivW-1:0]    LastCnt = DivW'(CLK_DIV - 1);

    logic [DivW-1:0]   div_q, div_d;
    logic              tick;
    state_e            state_q, state_d;
    logic              phase_en, shape_en;
    logic [DATA_W-1:0] wave;
    logic signed [DATA_W+4:0] prod;
    logic [DATA_W-1:0] scaled;
    logic [DATA_W-1:0] data_q, data_d;
    logic              lvalid_q, lvalid_d, rvalid_q, rvalid_d;
    logic [7:0]        ovr_q, ovr_d;
    logic              in_scale;

    audio_dds_core #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W)
    ) u_dds (
        .clk_i       (clk),
        .rst_i       (reset),
        .phase_en_i  (phase_en),
        .shape_en_i  (shape_en),
        .tune_word_i (tune_word),
        .wave_sel_i  (wave_sel),
        .wave_o      (wave)
    );

    always_comb begin
        tick  = enable && (div_q == LastCnt);
        div_d = (!enable || tick) ? '0 : div_q + 1'b1;
    end

    always_comb begin
        prod   = $signed(wave) * $signed({1'b0, volume});
        scaled = DATA_W'(prod >>> 4);
    end

    always_comb begin
        in_scale = (state_q == StScale);
        lvalid_d = in_scale ? !left_ready  : (lvalid_q && !left_ready);
        rvalid_d = in_scale ? !right_ready : (rvalid_q && !right_ready);
        data_d   = in_scale ? scaled : data_q;
    end

    always_comb begin
        state_d  = state_q;
        phase_en = 1'b0;
        shape_en = 1'b0;
        unique case (state_q)
            StIdle:  if (tick) state_d = StPhase;
            StPhase: begin
                phase_en = 1'b1;
                state_d  = StShape;
            end
            StShape: begin
                shape_en = 1'b1;
                state_d  = StScale;
            end
            StScale: state_d = StSend;
            // Leave as soon as both channels are done so the next tick is not lost.
            StSend:  if (!lvalid_d && !rvalid_d) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (tick && (state_q != StIdle) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            state_q  <= StIdle;
            data_q   <= '0;
            lvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            ovr_q    <= '0;
        end else begin
            div_q    <= div_d;
            state_q  <= state_d;
            data_q   <= data_d;
            lvalid_q <= lvalid_d;
            rvalid_q <= rvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    // The sample is offered straight from the scaler during SCALE, then held in data_q.
    assign left_data   = in_scale ? scaled : data_q;
    assign right_data  = in_scale ? scaled : data_q;
    assign left_valid  = in_scale | lvalid_q;
    assign right_valid = in_scale | rvalid_q;
    assign overrun_cnt = ovr_q;

endmodule
